// File: rtl/rr_grant_ctrl8_if.sv
// Request/grant bundle between the requesting units (master) and the arbiter (slave).
interface rr_grant_ctrl8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (output en, req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input en, req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_ctrl8.sv
// Eight-way round-robin arbiter for a decoder-selected shared resource, with
// hold-until-release grants and optional preemption after MAX_HOLD cycles.
module rr_grant_ctrl8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_grant_ctrl8_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    // Counter ceiling; with preemption disabled it simply parks at 255.
    localparam logic [7:0] SAT = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [2:0] id_q, id_nxt;
    logic       vld_q, vld_nxt;
    logic       to_q, to_nxt;
    logic [7:0] gnt_q;

    logic [2:0] winner;
    logic       found;
    logic       release_now;
    logic       preempt_now;

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        logic [2:0] idx;
        winner = ptr;
        found  = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign release_now = !bus.req[id_q];
    assign preempt_now = (MAX_HOLD != 0) && (hold_cnt == SAT) && bus.en &&
                         (|(bus.req & ~gnt_q));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        id_nxt    = id_q;
        vld_nxt   = vld_q;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                vld_nxt  = 1'b0;
                hold_nxt = 8'd0;
                if (bus.en && found) begin
                    state_nxt = BUSY;
                    id_nxt    = winner;
                    vld_nxt   = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = id_q + 3'd1;
                end else if (preempt_now) begin
                    state_nxt = IDLE;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = id_q + 3'd1;
                    to_nxt    = 1'b1;
                end else if (hold_cnt != SAT) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= 8'd0;
            id_q     <= 3'd0;
            vld_q    <= 1'b0;
            to_q     <= 1'b0;
            gnt_q    <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            id_q     <= id_nxt;
            vld_q    <= vld_nxt;
            to_q     <= to_nxt;
            gnt_q    <= vld_nxt ? (8'd1 << id_nxt) : 8'd0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Drives three arbiters (MAX_HOLD 4, 0, 2) with directed and random traffic and
// compares every cycle against a cycle-level reference model of the grant rules.
module tb_rr_grant_ctrl8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] req_v [3];
    logic       en_v  [3];
    logic [7:0] gnt_v [3];
    logic [2:0] id_v  [3];
    logic       vld_v [3];
    logic       to_v  [3];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rr_grant_ctrl8_if bus ();
        assign bus.req  = req_v[g];
        assign bus.en   = en_v[g];
        assign gnt_v[g] = bus.gnt;
        assign id_v[g]  = bus.gnt_id;
        assign vld_v[g] = bus.gnt_valid;
        assign to_v[g]  = bus.timeout;
        rr_grant_ctrl8 #(.MAX_HOLD((g == 0) ? 4 : (g == 1) ? 0 : 2)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 0 : 2;
    endfunction

    // Reference model: owner, pointer and how many cycles the grant has been visible.
    bit m_busy [3];
    int m_id   [3];
    int m_ptr  [3];
    int m_len  [3];
    bit m_to   [3];

    always @(posedge clk or negedge rst_n) begin
        bit b;
        bit t;
        int id;
        int p;
        int len;
        int h;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] <= 1'b0;
                m_id[i]   <= 0;
                m_ptr[i]  <= 0;
                m_len[i]  <= 0;
                m_to[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                b = m_busy[i]; id = m_id[i]; p = m_ptr[i]; len = m_len[i];
                t = 1'b0; h = hold_of(i);
                if (b) begin
                    if (!req_v[i][id]) begin
                        b = 1'b0; p = (id + 1) % 8;
                    end else if (h != 0 && len >= h && en_v[i] &&
                                 (req_v[i] & ~(8'd1 << id)) != 8'd0) begin
                        b = 1'b0; p = (id + 1) % 8; t = 1'b1;
                    end else begin
                        len++;
                    end
                end else if (en_v[i] && req_v[i] != 8'd0) begin
                    for (int k = 0; k < 8; k++)
                        if (!b && req_v[i][(p + k) % 8]) begin
                            b = 1'b1; id = (p + k) % 8; len = 1;
                        end
                end
                m_busy[i] <= b;
                m_id[i]   <= id;
                m_ptr[i]  <= p;
                m_len[i]  <= len;
                m_to[i]   <= t;
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("mdl_gnt", i, gnt_v[i], m_busy[i] ? (8'd1 << m_id[i]) : 8'd0);
            chk("mdl_id", i, 8'(id_v[i]), 8'(m_id[i]));
            chk("mdl_vld", i, 8'(vld_v[i]), 8'(m_busy[i]));
            chk("mdl_to", i, 8'(to_v[i]), 8'(m_to[i]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] pre_seq [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                                 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
    int rot_seq [3] = '{0, 7, 0};

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 8'h00;
            en_v[i]  = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_gnt", i, gnt_v[i], 8'h00);
            chk("rst_vld", i, 8'(vld_v[i]), 8'h00);
            chk("rst_id", i, 8'(id_v[i]), 8'h00);
        end
        rst_n = 1'b1;

        // Single request, release, then ptr=3 picks requester 3 out of all eight.
        req_v[0] = 8'h04; step();
        chk("single_gnt", 0, gnt_v[0], 8'h04);
        chk("single_id", 0, 8'(id_v[0]), 8'd2);
        chk("single_vld", 0, 8'(vld_v[0]), 8'd1);
        req_v[0] = 8'h00; step();
        chk("release_gnt", 0, gnt_v[0], 8'h00);
        req_v[0] = 8'hFF; step();
        chk("ptr3_id", 0, 8'(id_v[0]), 8'd3);
        req_v[0] = 8'h00; step();

        // Preemption between two continuous requesters.
        req_v[0] = 8'h03;
        for (int k = 0; k < 11; k++) begin
            step();
            chk("pre_gnt", 0, gnt_v[0], pre_seq[k]);
            chk("pre_to", 0, 8'(to_v[0]), (pre_seq[k] == 8'h00) ? 8'd1 : 8'd0);
        end
        req_v[0] = 8'h00; step(); step();

        // Alone: no preemption however long, until someone else asks.
        req_v[0] = 8'h10;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("alone_gnt", 0, gnt_v[0], 8'h10);
        end
        req_v[0] = 8'h12; step();
        chk("late_pre_gnt", 0, gnt_v[0], 8'h00);
        chk("late_pre_to", 0, 8'(to_v[0]), 8'd1);
        step();
        chk("late_pre_next", 0, gnt_v[0], 8'h02);
        req_v[0] = 8'h00; step();

        // Rotation with wrap on the no-preemption instance.
        req_v[1] = 8'h81;
        for (int g = 0; g < 3; g++) begin
            step();
            chk("rot_id", 1, 8'(id_v[1]), 8'(rot_seq[g]));
            chk("rot_vld", 1, 8'(vld_v[1]), 8'd1);
            step(); step();
            req_v[1] = 8'h81 & ~(8'd1 << rot_seq[g]);
            step();
            chk("rot_dead", 1, 8'(vld_v[1]), 8'd0);
            req_v[1] = 8'h81;
        end
        en_v[1] = 1'b0; req_v[1] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("en_off_vld", 1, 8'(vld_v[1]), 8'd0);
        end
        en_v[1] = 1'b1; step();
        chk("en_on_id", 1, 8'(id_v[1]), 8'd1);
        req_v[1] = 8'h00; step();

        // Release coinciding with the would-be timeout.
        req_v[2] = 8'h20; step();
        chk("col_gnt", 2, gnt_v[2], 8'h20);
        req_v[2] = 8'h21; step();
        chk("col_hold", 2, gnt_v[2], 8'h20);
        req_v[2] = 8'h01; step();
        chk("col_vld", 2, 8'(vld_v[2]), 8'd0);
        chk("col_to", 2, 8'(to_v[2]), 8'd0);
        req_v[2] = 8'h61; step();
        chk("col_ptr6", 2, 8'(id_v[2]), 8'd6);
        req_v[2] = 8'h00; step();

        // Random traffic, reacting to the model's view of who holds the grant.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                logic [7:0] r;
                r = req_v[i];
                en_v[i] = ($urandom_range(0, 19) != 0);
                for (int b = 0; b < 8; b++) begin
                    if (r[b]) begin
                        if (m_busy[i] && m_id[i] == b) begin
                            if ($urandom_range(0, 5) == 0) r[b] = 1'b0;
                        end else if ($urandom_range(0, 39) == 0) begin
                            r[b] = 1'b0;
                        end
                    end else if ($urandom_range(0, 9) == 0) begin
                        r[b] = 1'b1;
                    end
                end
                req_v[i] = r;
            end
            step();
        end

        // Asynchronous reset in the middle of a grant.
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 8'h00;
            en_v[i]  = 1'b1;
        end
        step(); step();
        req_v[0] = 8'h40; step();
        chk("ar_pre_gnt", 0, gnt_v[0], 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt", 0, gnt_v[0], 8'h00);
        chk("ar_vld", 0, 8'(vld_v[0]), 8'd0);
        chk("ar_to", 0, 8'(to_v[0]), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_v[0] = 8'hC1; step();
        chk("ar_ptr0", 0, 8'(id_v[0]), 8'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_grant_ctrl8.md
# rr_grant_ctrl8

Round-robin arbiter/controller that shares one 3-to-8 decoded resource among eight requesters. It picks one requester, holds the grant until that requester releases it, and optionally preempts a requester that holds the grant too long. It drives the resource's binary select and enable (`gnt_id`, `gnt_valid`) together with the equivalent one-hot grant vector. It sits between the requesting units and the decoder-selected shared resource.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles when others are waiting; range 0..255; 0 disables preemption.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `en`  input  1  arbitration enable; when 0, no new grant and no preemption; an active grant continues.
- `req`  input  8  request vector; bit i held high for as long as requester i needs the resource.
- `gnt`  output  8  one-hot grant; always equals a 3-to-8 decode of `gnt_id` gated by `gnt_valid`.
- `gnt_id`  output  3  binary index of the granted requester; holds its last value when `gnt_valid`=0.
- `gnt_valid`  output  1  a grant is active (decoder enable).
- `timeout`  output  1  one-cycle pulse in the cycle after a grant is preempted.

## Operation
- State: 2-state FSM (IDLE, BUSY), 3-bit priority pointer `ptr`, 8-bit hold counter `hold_cnt`. All outputs are registered.
- Reset (async, `rst_n`=0): state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0. Asserting reset mid-grant drops the grant immediately, without waiting for a clock edge.
- IDLE, when `en`=1 and `req`≠0:
  - Winner = first set bit of `req`, searching ptr, ptr+1, …, ptr+7 (mod 8).
  - Next state BUSY; `gnt_id`=winner; `gnt_valid`=1; `hold_cnt`=0.
- IDLE, when `en`=0 or `req`=0: remain in IDLE with outputs cleared.
- BUSY, evaluated in this priority order:
  - Release, `req[gnt_id]`=0: next state IDLE, `gnt_valid`=0, `ptr`=gnt_id+1 (mod 8, so 7 wraps to 0).
  - Preempt, all of:
    - `MAX_HOLD`≠0,
    - `hold_cnt`=MAX_HOLD−1,
    - `en`=1,
    - (`req` & ~`gnt`)≠0.
    
    Action: next state IDLE, `gnt_valid`=0, `ptr`=gnt_id+1, `timeout`=1 for one cycle.
  - Otherwise remain in BUSY. `hold_cnt` increments and saturates at MAX_HOLD−1; when `MAX_HOLD`=0 it saturates at 255.
- Release and preempt in the same cycle: release wins, and `timeout` stays 0.
- A preempted requester that keeps `req` high is treated as a new request at lowest priority.
- `req` bits that are not granted have no effect until the next IDLE arbitration.
- `en` falling during BUSY: the grant continues until release; no preemption occurs.

## Timing
- Request to grant: `req` is sampled high in IDLE at edge N; `gnt`/`gnt_valid` are high from edge N onward. This is 1 cycle of latency.
- Release to dead cycle: `req[gnt_id]` sampled low at edge M; `gnt` is 0 from edge M. This gives exactly one grant-free cycle (IDLE). The next grant appears at edge M+1 if requests are pending.
- Grant length under contention: exactly MAX_HOLD cycles of `gnt_valid`=1, then 1 dead cycle. `timeout` is high during that dead cycle.
- `gnt`, `gnt_id` and `gnt_valid` change only together and only at a clock edge (except on reset). `gnt` is never multi-hot.

## Test plan
- Reset and single request:
  - Stimulus: `rst_n` low, then high; `en`=1; `req`=8'h04.
  - Required: after reset all outputs are 0. Next edge: `gnt`=8'h04, `gnt_id`=2, `gnt_valid`=1. Drop `req` → `gnt`=0 on the following edge; `ptr`=3.
- Round-robin rotation with wrap:
  - Stimulus: `MAX_HOLD`=0; `req`=8'h81 held; each winner releases after 3 cycles then re-requests.
  - Required: grant order is 0, 7, 0, 7, …, with one dead cycle between grants. After 7 is served, `ptr` wraps to 0.
- Preemption:
  - Stimulus: `MAX_HOLD`=4; `req`=8'h03 held continuously.
  - Required: `gnt`=8'h01 for exactly 4 cycles, then 1 dead cycle with `timeout`=1, then `gnt`=8'h02 for 4 cycles, then back to 8'h01.
- No preemption when alone:
  - Stimulus: `MAX_HOLD`=4; `req`=8'h10 for 20 cycles; then assert `req[1]` at cycle 20.
  - Required: `gnt`=8'h10 through cycle 20. Preemption follows on the next edge (counter saturated); `timeout` pulses; then `gnt`=8'h02.
- Release/timeout collision and enable:
  - Stimulus 1: `MAX_HOLD`=2; requester 5 drops `req` in the same cycle its timeout would fire.
    - Required: `timeout` stays 0 and `ptr`=6.
  - Stimulus 2: with `en`=0 and `req`=8'hFF.
    - Required: no grant is issued. Raising `en` → grant goes to the index at `ptr`.
- Async reset mid-grant:
  - Stimulus: assert `rst_n`=0 between clock edges while `gnt`=8'h40.
  - Required: `gnt`, `gnt_valid` and `timeout` go to 0 immediately. After release, the first grant follows priority from `ptr`=0.
